// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the I-cache, D-cache and backing-memory signals of mem_port_arbiter.
//   master : arbiter side (takes requests and mem_rdata/mem_resp; drives resps, rdata and the mem_* port)
//   slave  : environment side (caches plus memory adapter), with all directions reversed
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] i_addr;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic [ADDR_W-1:0] d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  modport master (
    input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_read, mem_write, mem_wdata
  );
  modport slave (
    output i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one cacheline memory port between I-cache and D-cache.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mem_port_arbiter_if.master (cache requests/responses and the downstream mem_* port)
//   Optional MEM_ARB_PERF_CNT_EN adds i_grant_cnt, d_grant_cnt, i_wait_cnt, d_wait_cnt (32-bit, wrapping).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]        i_grant_cnt,
  output logic [31:0]        d_grant_cnt,
  output logic [31:0]        i_wait_cnt,
  output logic [31:0]        d_wait_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t            state_q, state_d;
  logic              last_is_d_q, last_is_d_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              i_req, d_req, grant_i, grant_d, serve;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_is_d_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_is_d_q <= last_is_d_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
    end
  end
  // Grants happen only in IDLE, so a completed transaction always sees one IDLE cycle before the next grant.
  always_comb begin
    i_req         = bus.i_read;
    d_req         = bus.d_read | bus.d_write;
    grant_d       = state_q == IDLE && d_req && (!i_req || !last_is_d_q);
    grant_i       = state_q == IDLE && i_req && !grant_d;
    serve         = state_q != IDLE;
    state_d       = grant_d ? SERVE_D : grant_i ? SERVE_I : serve && bus.mem_resp ? IDLE : state_q;
    last_is_d_d   = grant_d ? 1'b1 : grant_i ? 1'b0 : last_is_d_q;
    addr_d        = grant_d ? bus.d_addr : grant_i ? bus.i_addr : addr_q;
    wr_d          = grant_d ? bus.d_write : grant_i ? 1'b0 : wr_q;
    wdata_d       = grant_d && bus.d_write ? bus.d_wdata : grant_i || grant_d ? '0 : wdata_q;
    bus.mem_addr  = serve ? addr_q : '0;
    bus.mem_wdata = serve ? wdata_q : '0;
    bus.mem_read  = serve && !wr_q;
    bus.mem_write = serve && wr_q;
    bus.i_resp    = state_q == SERVE_I && bus.mem_resp;
    bus.d_resp    = state_q == SERVE_D && bus.mem_resp;
    bus.i_rdata   = bus.i_resp ? bus.mem_rdata : '0;
    bus.d_rdata   = bus.d_resp ? bus.mem_rdata : '0;
  end
`ifdef MEM_ARB_PERF_CNT_EN
  // A requester waits whenever it asks but neither owns the port nor wins the IDLE arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
      i_wait_cnt  <= '0;
      d_wait_cnt  <= '0;
    end else begin
      i_grant_cnt <= i_grant_cnt + 32'(grant_i);
      d_grant_cnt <= d_grant_cnt + 32'(grant_d);
      i_wait_cnt  <= i_wait_cnt + 32'(i_req && state_q != SERVE_I && !grant_i);
      d_wait_cnt  <= d_wait_cnt + 32'(d_req && state_q != SERVE_D && !grant_d);
    end
  end
`endif
`ifndef SYNTHESIS
  // After a reset the adapter may still deliver a stale completion until the next grant; that one is expected.
  logic post_rst_q;
  always_ff @(posedge clk) post_rst_q <= rst || (post_rst_q && !(grant_i || grant_d));
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (rst) !(bus.d_read && bus.d_write));
  a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst) !(state_q == IDLE && bus.mem_resp && !post_rst_q));
`endif
endmodule
